// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the fetch address and builds the
// IF/ID register, applying redirect > flush > stall > normal-fetch priority.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter int unsigned MEM_BYTES = 1000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        STALL,
  input  logic        FLUSH,
  input  logic        REDIR,
  input  logic [31:0] TGT,
  output logic [31:0] DR,
  input  logic [31:0] INS,
  output logic [31:0] ID_INS,
  output logic [31:0] ID_PC,
  output logic [31:0] ID_NPC,
  output logic        ID_VALID,
  output logic        ERR
);

  localparam logic [31:0] LAST_ADDR = 32'(MEM_BYTES - 4);

  logic [31:0] pc_q, pc_d;
  logic [31:0] id_ins_q, id_ins_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_npc_q, id_npc_d;
  logic        id_valid_q, id_valid_d;
  logic        err_q, err_d;

  logic [32:0] pc_inc;
  logic [31:0] seq_pc;
  logic        tgt_legal;

  // Widened increment so the wrap compare cannot be fooled by 32-bit overflow.
  assign pc_inc    = {1'b0, pc_q} + 33'd4;
  assign seq_pc    = (pc_inc <= {1'b0, LAST_ADDR}) ? pc_inc[31:0] : RESET_PC;
  assign tgt_legal = (TGT[1:0] == 2'b00) && (TGT <= LAST_ADDR);

  always_comb begin
    pc_d       = pc_q;
    id_ins_d   = id_ins_q;
    id_pc_d    = id_pc_q;
    id_npc_d   = id_npc_q;
    id_valid_d = id_valid_q;
    err_d      = err_q;
    if (REDIR) begin
      id_valid_d = 1'b0;
      id_ins_d   = 32'd0;
      if (tgt_legal) begin
        pc_d = TGT;
      end else begin
        pc_d  = RESET_PC;
        err_d = 1'b1;
      end
    end else if (FLUSH) begin
      id_valid_d = 1'b0;
      id_ins_d   = 32'd0;
      if (!STALL) begin
        pc_d = seq_pc;
      end
    end else if (!STALL) begin
      id_ins_d   = INS;
      id_pc_d    = pc_q;
      id_npc_d   = pc_inc[31:0];
      id_valid_d = 1'b1;
      pc_d       = seq_pc;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc_q       <= RESET_PC;
      id_ins_q   <= 32'd0;
      id_pc_q    <= 32'd0;
      id_npc_q   <= 32'd0;
      id_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      id_ins_q   <= id_ins_d;
      id_pc_q    <= id_pc_d;
      id_npc_q   <= id_npc_d;
      id_valid_q <= id_valid_d;
      err_q      <= err_d;
    end
  end

  assign DR       = pc_q;
  assign ID_INS   = id_ins_q;
  assign ID_PC    = id_pc_q;
  assign ID_NPC   = id_npc_q;
  assign ID_VALID = id_valid_q;
  assign ERR      = err_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed test-plan steps followed by randomized control
// traffic, all checked against a behavioural model of the fetch rules.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC  = 32'd0;
  localparam int unsigned MEM_BYTES = 1000;
  localparam int          NWORDS    = MEM_BYTES / 4;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        STALL = 1'b0, FLUSH = 1'b0, REDIR = 1'b0;
  logic [31:0] TGT = 32'd0;
  logic [31:0] DR, INS, ID_INS, ID_PC, ID_NPC;
  logic        ID_VALID, ERR;

  logic [31:0] mem [0:NWORDS-1];

  int n_cmp = 0;
  int n_err = 0;

  // Model state
  logic [31:0] m_pc, m_ins, m_ipc, m_inpc;
  logic        m_vld, m_err;

  fetch_stage #(.RESET_PC(RESET_PC), .MEM_BYTES(MEM_BYTES)) dut (
    .CLK(CLK), .RST_N(RST_N), .STALL(STALL), .FLUSH(FLUSH), .REDIR(REDIR),
    .TGT(TGT), .DR(DR), .INS(INS), .ID_INS(ID_INS), .ID_PC(ID_PC),
    .ID_NPC(ID_NPC), .ID_VALID(ID_VALID), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  always_comb begin
    INS = 32'hDEAD_BEEF;
    if (DR <= MEM_BYTES - 4) INS = mem[DR / 4];
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".DR"},       DR,              m_pc);
    check({tag, ".ID_INS"},   ID_INS,          m_ins);
    check({tag, ".ID_PC"},    ID_PC,           m_ipc);
    check({tag, ".ID_NPC"},   ID_NPC,          m_inpc);
    check({tag, ".ID_VALID"}, {31'd0, ID_VALID}, {31'd0, m_vld});
    check({tag, ".ERR"},      {31'd0, ERR},    {31'd0, m_err});
  endtask

  function automatic logic [31:0] next_seq(input logic [31:0] pc);
    longint nxt = longint'(pc) + 4;
    return (nxt <= longint'(MEM_BYTES) - 4) ? 32'(nxt) : RESET_PC;
  endfunction

  function automatic bit legal(input logic [31:0] t);
    return (t % 4 == 0) && (longint'(t) <= longint'(MEM_BYTES) - 4);
  endfunction

  task automatic model_reset();
    m_pc = RESET_PC; m_ins = 0; m_ipc = 0; m_inpc = 0; m_vld = 0; m_err = 0;
  endtask

  // One clock edge: predict from the inputs in force, then compare just after the edge.
  task automatic step(input string tag);
    logic [31:0] pc, ins, ipc, inpc;
    logic vld, er;
    pc = m_pc; ins = m_ins; ipc = m_ipc; inpc = m_inpc; vld = m_vld; er = m_err;
    if (REDIR) begin
      vld = 0; ins = 0;
      if (legal(TGT)) pc = TGT;
      else begin pc = RESET_PC; er = 1; end
    end else if (FLUSH) begin
      vld = 0; ins = 0;
      if (!STALL) pc = next_seq(m_pc);
    end else if (!STALL) begin
      ins = mem[m_pc / 4]; ipc = m_pc; inpc = m_pc + 32'd4; vld = 1;
      pc = next_seq(m_pc);
    end
    @(posedge CLK);
    if (RST_N) begin
      m_pc = pc; m_ins = ins; m_ipc = ipc; m_inpc = inpc; m_vld = vld; m_err = er;
    end
    #1;
    check_all(tag);
  endtask

  task automatic ctrl(input logic s, input logic f, input logic r, input logic [31:0] t);
    STALL = s; FLUSH = f; REDIR = r; TGT = t;
  endtask

  // Called just after a check point; reset falls between edges and releases on the falling edge.
  task automatic reset_pulse(input string tag);
    #2;
    RST_N = 1'b0;
    model_reset();
    #1;
    check_all(tag);
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < NWORDS; i++) mem[i] = $urandom;
    mem[0] = 32'h1111_1111;
    mem[1] = 32'h2222_2222;
    mem[2] = 32'h3333_3333;
    model_reset();

    #3;
    check_all("reset");
    @(negedge CLK);
    RST_N = 1'b1;

    // Free-running fetch
    ctrl(0, 0, 0, 0);
    step("fetch0");
    check("fetch0.dr", DR, 32'd4);
    check("fetch0.ins", ID_INS, 32'h1111_1111);
    check("fetch0.npc", ID_NPC, 32'd4);
    check("fetch0.vld", {31'd0, ID_VALID}, 32'd1);
    step("fetch1");
    check("fetch1.dr", DR, 32'd8);
    check("fetch1.ins", ID_INS, 32'h2222_2222);

    // Two-cycle stall at PC=8
    ctrl(1, 0, 0, 0);
    step("stall0");
    step("stall1");
    check("stall.dr", DR, 32'd8);
    check("stall.ins", ID_INS, 32'h2222_2222);
    ctrl(0, 0, 0, 0);
    step("unstall");
    check("unstall.ins", ID_INS, 32'h3333_3333);
    check("unstall.pc", ID_PC, 32'd8);
    check("unstall.dr", DR, 32'd12);

    // Redirect wins over stall
    ctrl(1, 0, 1, 32'h40);
    step("redir_stall");
    check("redir.dr", DR, 32'h40);
    check("redir.vld", {31'd0, ID_VALID}, 32'd0);
    check("redir.ins", ID_INS, 32'd0);
    ctrl(0, 0, 0, 0);
    step("redir_tgt");
    check("redir_tgt.pc", ID_PC, 32'h40);
    check("redir_tgt.vld", {31'd0, ID_VALID}, 32'd1);

    // Illegal targets: misaligned, then past the end
    ctrl(0, 0, 1, 32'h42);
    step("bad_align");
    check("bad_align.err", {31'd0, ERR}, 32'd1);
    check("bad_align.dr", DR, RESET_PC);
    ctrl(0, 0, 0, 0);
    step("after_bad0");
    ctrl(0, 0, 1, 32'd1000);
    step("bad_range");
    check("bad_range.err", {31'd0, ERR}, 32'd1);
    check("bad_range.dr", DR, RESET_PC);
    ctrl(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("err_sticky");
    check("err_sticky.err", {31'd0, ERR}, 32'd1);

    // Wrap at the last word
    ctrl(0, 0, 1, 32'd996);
    step("to_996");
    ctrl(0, 0, 0, 0);
    step("wrap");
    check("wrap.pc", ID_PC, 32'd996);
    check("wrap.npc", ID_NPC, 32'd1000);
    check("wrap.dr", DR, 32'd0);

    // Flush with and without stall
    ctrl(0, 1, 0, 0);
    step("flush");
    ctrl(1, 1, 0, 0);
    step("flush_stall");
    ctrl(0, 0, 0, 0);
    step("post_flush");

    // Async reset with PC=20 and a valid IF/ID
    ctrl(0, 0, 1, 32'd16);
    step("to_16");
    ctrl(0, 0, 0, 0);
    step("to_20");
    check("pre_rst.dr", DR, 32'd20);
    reset_pulse("async_rst");
    check("async_rst.err", {31'd0, ERR}, 32'd0);
    step("post_rst");
    check("post_rst.ins", ID_INS, 32'h1111_1111);
    check("post_rst.pc", ID_PC, 32'd0);

    // Randomized control traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] t;
      int sel;
      sel = $urandom_range(0, 99);
      if (sel < 70)      t = $urandom_range(0, NWORDS - 1) * 4;
      else if (sel < 85) t = ($urandom_range(0, NWORDS - 1) * 4) | $urandom_range(1, 3);
      else               t = $urandom_range(MEM_BYTES, MEM_BYTES + 64) & ~32'd3;
      ctrl($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 11) == 0, t);
      step("rand");
      if ($urandom_range(0, 99) < 2) begin
        ctrl(0, 0, 0, 0);
        reset_pulse("rand_rst");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
